hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational ID-stage hazard detector.
- Holds its own DEPTH-stage shadow of in-flight destinations (EXE onward) instead of taking per-stage dest/WB_EN ports.
- Produces load-use, branch and no-forwarding stalls, per-source forward-select codes and a saturating stall-cycle counter.
- Sits beside the ID stage; its stall output gates the PC/IF-ID registers and inserts a bubble into EXE.

Parameters:
- REG_W, 5, register index width.
- DEPTH, 2, tracked stages after ID (index 0 = EXE, 1 = MEM, ...); legal range 1..7.
- ALU_AVAIL, 0, lowest stage index from which a non-load result is forwardable to the ID instruction's EXE.
- LOAD_AVAIL, 1, same for loads (mem_r_en set).
- BR_EXTRA, 2, extra stages a branch needs, because it reads its operands in ID.
- ZERO_IS_CONST, 1, when 1 register 0 never creates a hazard.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1, id_src2  in  REG_W each  source registers.
- id_is_imm  in  1  src2 field is an immediate.
- id_st_or_bne  in  1  src2 is read anyway (store or BNE).
- id_dest  in  REG_W  destination register.
- id_wb_en  in  1  writes back.
- id_mem_r_en  in  1  is a load.
- id_br_cmd  in  brcmd_t  COND_JUMP / COND_BEZ / COND_BNE.
- forward_en  in  1  forwarding enabled.
- flush  in  1  kill the ID instruction (taken branch).
- pipe_hold  in  1  downstream freeze; the shadow does not advance.
- stall  out  1  combinational; hold IF/ID, bubble EXE.
- fwd_sel1, fwd_sel2  out  3 each  0 = register file, k+1 = forward from stage k.
- stall_cnt  out  CNT_W  hazard-stall cycles.
- inflight  out  3  count of valid shadow entries.

Behaviour:
- Shadow entry fields: {v, dest, mem_r}. On reset all v = 0, stall_cnt = 0, inflight = 0.
- src2 is used when (!id_is_imm || id_st_or_bne). src1 is always used.
- An entry at stage k matches a used source s when: v && dest == s && !(ZERO_IS_CONST && s == 0).
- avail(entry) = mem_r ? LOAD_AVAIL : ALU_AVAIL.
- is_br = (id_br_cmd == COND_BEZ || id_br_cmd == COND_BNE).
- A matching entry at stage k causes a hazard when:
  - forward_en == 0: always.
  - forward_en == 1: k < avail + (is_br ? BR_EXTRA : 0).
- stall = id_valid && !flush && (any hazard || pipe_hold).
- fwd_sel per source:
  - Picks the smallest matching k and outputs k+1.
  - Forced to 0 when forward_en == 0, stall == 1, there is no match, or the source is unused.
  - The youngest entry wins over older ones for the same register.
- Advance rule, evaluated at each rising edge:
  - When pipe_hold == 0, every entry moves to stage k+1 and the entry at DEPTH-1 retires.
  - Stage 0 loads {1, id_dest, id_mem_r_en} when id_valid && !stall && !flush && id_wb_en; otherwise it loads a bubble (v = 0).
  - When pipe_hold == 1, the shadow is frozen; no insert and no shift.
- flush and stall in the same cycle: flush wins; stall = 0 and a bubble is inserted.
- stall_cnt increments by 1 on each cycle with id_valid && hazard && !flush. pipe_hold-only stalls are not counted. It saturates at all-ones and does not wrap.
- inflight = popcount of v, registered, updated with the shadow.
- Reset asserted mid-stall clears the shadow: stall drops the following cycle unless pipe_hold is high.
- Latency:
  - stall and fwd_sel are same-cycle combinational.
  - Shadow updates take one cycle.

Decomposition:
- hazard_pkg holds:
  - brcmd_t (COND_JUMP, COND_BEZ, COND_BNE; explicit 2-bit encoding 0/1/2);
  - the sb_entry_t struct;
  - the FWD_RF = 0 constant.
- One sub-module, hazard_src_match: one instance per source. It takes the shadow vector, src, used, is_br and forward_en, and returns hazard and fwd_sel.

Test Plan:
- ALU then dependent ALU, forward_en = 1: dest = 3, next src1 = 3 -> stall = 0, fwd_sel1 = 1; next cycle a src2 = 3 dependent -> fwd_sel2 = 2.
- Load-use: load dest = 5, next src1 = 5, forward_en = 1 -> stall = 1 for exactly 1 cycle, then fwd_sel1 = 2, stall_cnt = 1.
- BNE on a load result: load dest = 7, BNE src2 = 7 with id_is_imm = 1 and id_st_or_bne = 1 -> stall 3 cycles (k = 0, 1, 2 < 3), stall_cnt = 3.
- forward_en = 0, dest = 4 then src1 = 4, DEPTH = 2 -> stall 2 cycles, fwd_sel1 = 0 throughout.
- Register 0 / immediate masking:
  - dest = 0 then src1 = 0 -> no stall.
  - dest = 6 then src2 = 6 with id_is_imm = 1 and id_st_or_bne = 0 -> no stall.
- Control interactions:
  - flush together with a hazard -> stall = 0 and a bubble is inserted.
  - pipe_hold for 3 cycles -> shadow frozen and inflight unchanged.
  - stall_cnt with CNT_W = 2 saturates at 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scoreboard.
//   brcmd_t    : branch command carried by the ID instruction
//   sb_entry_t : one shadow slot {valid, destination register, is-load}
//   FWD_RF     : forward-select code meaning "read the register file"
// Destination fields are held at SB_DEST_W bits, so REG_W may be at most 8.
package hazard_pkg;

  typedef enum logic [1:0] {
    COND_JUMP = 2'd0,
    COND_BEZ  = 2'd1,
    COND_BNE  = 2'd2
  } brcmd_t;

  localparam int SB_DEST_W = 8;

  typedef struct packed {
    logic                 v;
    logic [SB_DEST_W-1:0] dest;
    logic                 mem_r;
  } sb_entry_t;

  localparam logic [2:0] FWD_RF = 3'd0;

endpackage

// File: rtl/hazard_src_match.sv
// Per-source hazard check against the in-flight shadow.
//   shadow     : DEPTH entries, index 0 = EXE (youngest)
//   src        : source register read by the ID instruction
//   used       : the source is actually read
//   is_br      : ID instruction is a BEZ/BNE (operands needed in ID)
//   forward_en : forwarding paths are enabled
//   hazard     : some matching entry is not yet forwardable
//   fwd_sel    : 0 = register file, k+1 = youngest match at stage k
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int DEPTH         = 2,
  parameter int ALU_AVAIL     = 0,
  parameter int LOAD_AVAIL    = 1,
  parameter int BR_EXTRA      = 2,
  parameter int ZERO_IS_CONST = 1
) (
  input  sb_entry_t [DEPTH-1:0] shadow,
  input  logic [REG_W-1:0]      src,
  input  logic                  used,
  input  logic                  is_br,
  input  logic                  forward_en,
  output logic                  hazard,
  output logic [2:0]            fwd_sel
);

  logic src_live;

  // First stage index at which the entry's result can reach this instruction.
  function automatic int ready_stage(input logic mem_r, input logic br);
    return (mem_r ? LOAD_AVAIL : ALU_AVAIL) + (br ? BR_EXTRA : 0);
  endfunction

  assign src_live = used && !((ZERO_IS_CONST != 0) && (src == '0));

  // Walk oldest to youngest so the youngest match is the last to set fwd_sel.
  always_comb begin
    hazard  = 1'b0;
    fwd_sel = FWD_RF;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (src_live && shadow[k].v && (shadow[k].dest == SB_DEST_W'(src))) begin
        if (!forward_en || (k < ready_stage(shadow[k].mem_r, is_br))) hazard = 1'b1;
        if (forward_en) fwd_sel = 3'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard with its own shadow of in-flight destinations.
//   clk, rst_n         : clock, synchronous active-low reset
//   id_*               : decoded fields of the instruction sitting in ID
//   forward_en         : forwarding paths enabled
//   flush              : kill the ID instruction (taken branch)
//   pipe_hold          : downstream freeze; shadow does not advance
//   stall              : combinational; hold PC/IF-ID and bubble EXE
//   fwd_sel1/fwd_sel2  : 0 = register file, k+1 = forward from stage k
//   stall_cnt          : saturating count of hazard-stall cycles
//   inflight           : number of valid shadow entries
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W         = 5,
  parameter int DEPTH         = 2,
  parameter int ALU_AVAIL     = 0,
  parameter int LOAD_AVAIL    = 1,
  parameter int BR_EXTRA      = 2,
  parameter int ZERO_IS_CONST = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_is_imm,
  input  logic             id_st_or_bne,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  brcmd_t           id_br_cmd,
  input  logic             forward_en,
  input  logic             flush,
  input  logic             pipe_hold,
  output logic             stall,
  output logic [2:0]       fwd_sel1,
  output logic [2:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [2:0]       inflight
);

  sb_entry_t [DEPTH-1:0] shadow_p0;
  sb_entry_t [DEPTH-1:0] shadow_nxt;
  logic                  src2_used;
  logic                  is_br;
  logic                  haz1, haz2, hazard;
  logic                  insert;
  logic [2:0]            sel1_raw, sel2_raw;

  function automatic logic [2:0] count_valid(input sb_entry_t [DEPTH-1:0] sh);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < DEPTH; k++) n = n + 3'(sh[k].v);
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign src2_used = !id_is_imm || id_st_or_bne;
  assign is_br     = (id_br_cmd == COND_BEZ) || (id_br_cmd == COND_BNE);

  hazard_src_match #(
    .REG_W(REG_W), .DEPTH(DEPTH), .ALU_AVAIL(ALU_AVAIL), .LOAD_AVAIL(LOAD_AVAIL),
    .BR_EXTRA(BR_EXTRA), .ZERO_IS_CONST(ZERO_IS_CONST)
  ) u_src1 (
    .shadow(shadow_p0), .src(id_src1), .used(1'b1), .is_br(is_br),
    .forward_en(forward_en), .hazard(haz1), .fwd_sel(sel1_raw)
  );

  hazard_src_match #(
    .REG_W(REG_W), .DEPTH(DEPTH), .ALU_AVAIL(ALU_AVAIL), .LOAD_AVAIL(LOAD_AVAIL),
    .BR_EXTRA(BR_EXTRA), .ZERO_IS_CONST(ZERO_IS_CONST)
  ) u_src2 (
    .shadow(shadow_p0), .src(id_src2), .used(src2_used), .is_br(is_br),
    .forward_en(forward_en), .hazard(haz2), .fwd_sel(sel2_raw)
  );

  assign hazard = haz1 || haz2;
  // flush beats any hazard: the killed instruction must not hold the front end.
  assign stall    = id_valid && !flush && (hazard || pipe_hold);
  assign fwd_sel1 = stall ? FWD_RF : sel1_raw;
  assign fwd_sel2 = stall ? FWD_RF : sel2_raw;
  assign insert   = id_valid && !stall && !flush && id_wb_en;

  always_comb begin
    shadow_nxt = shadow_p0;
    if (!pipe_hold) begin
      for (int k = DEPTH - 1; k > 0; k--) shadow_nxt[k] = shadow_p0[k-1];
      shadow_nxt[0].v     = insert;
      shadow_nxt[0].dest  = SB_DEST_W'(id_dest);
      shadow_nxt[0].mem_r = id_mem_r_en;
    end
  end

  // ---- stage boundary: ID -> shadow (EXE onward) ----
  // Only the valid bits need clearing; dest/mem_r are ignored while v = 0.
  always_ff @(posedge clk) begin
    shadow_p0 <= shadow_nxt;
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) shadow_p0[k].v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      inflight  <= '0;
    end else begin
      inflight <= count_valid(shadow_nxt);
      if (id_valid && hazard && !flush) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, id_valid, id_is_imm, id_st_or_bne, id_wb_en, id_mem_r_en;
  logic       forward_en, flush, pipe_hold;
  logic [4:0] id_src1, id_src2, id_dest;
  brcmd_t     id_br_cmd;

  logic        stall0, stall1;
  logic [2:0]  sel1_0, sel2_0, sel1_1, sel2_1, infl0, infl1;
  logic [31:0] cnt0_o;
  logic [1:0]  cnt1_o;

  hazard_scoreboard #(.DEPTH(2), .CNT_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_is_imm(id_is_imm), .id_st_or_bne(id_st_or_bne), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_br_cmd(id_br_cmd),
    .forward_en(forward_en), .flush(flush), .pipe_hold(pipe_hold),
    .stall(stall0), .fwd_sel1(sel1_0), .fwd_sel2(sel2_0), .stall_cnt(cnt0_o), .inflight(infl0)
  );

  hazard_scoreboard #(.DEPTH(3), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_is_imm(id_is_imm), .id_st_or_bne(id_st_or_bne), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_br_cmd(id_br_cmd),
    .forward_en(forward_en), .flush(flush), .pipe_hold(pipe_hold),
    .stall(stall1), .fwd_sel1(sel1_1), .fwd_sel2(sel2_1), .stall_cnt(cnt1_o), .inflight(infl1)
  );

  // Reference model: each instance's in-flight list as a queue, youngest first.
  typedef struct packed {logic v; logic [4:0] dest; logic mr;} ent_t;
  typedef struct packed {logic haz; logic stall; logic [2:0] sel1; logic [2:0] sel2;} exp_t;

  ent_t   sh0[$];
  ent_t   sh1[$];
  longint cnt0, cnt1;
  exp_t   e0, e1;
  int     nassert = 0;
  int     nfail   = 0;
  int     ns0, ns1;

  function automatic exp_t model_eval(input ent_t sh[$]);
    exp_t r;
    int   src [2];
    bit   used[2];
    int   sel [2];
    bit   haz, br;
    int   need;
    src[0]  = int'(id_src1);
    src[1]  = int'(id_src2);
    used[0] = 1'b1;
    used[1] = !id_is_imm || id_st_or_bne;
    br      = (id_br_cmd == COND_BEZ) || (id_br_cmd == COND_BNE);
    haz     = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel[s] = 0;
      if (used[s] && src[s] != 0) begin
        for (int k = 0; k < sh.size(); k++) begin
          if (sh[k].v && int'(sh[k].dest) == src[s]) begin
            // load results are ready from MEM (1), ALU from EXE (0); branches need 2 more
            need = (sh[k].mr ? 1 : 0) + (br ? 2 : 0);
            if (!forward_en || k < need) haz = 1'b1;
            if (sel[s] == 0) sel[s] = k + 1;
          end
        end
      end
    end
    r.haz   = haz;
    r.stall = id_valid && !flush && (haz || pipe_hold);
    r.sel1  = (forward_en && !r.stall) ? 3'(sel[0]) : 3'd0;
    r.sel2  = (forward_en && !r.stall) ? 3'(sel[1]) : 3'd0;
    return r;
  endfunction

  function automatic int popcnt(input ent_t sh[$]);
    int n = 0;
    foreach (sh[k]) if (sh[k].v) n++;
    return n;
  endfunction

  function automatic ent_t killed(input ent_t x);
    ent_t y = x;
    y.v = 1'b0;
    return y;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic settle(input bit chk);
    @(negedge clk);
    e0 = model_eval(sh0);
    e1 = model_eval(sh1);
    if (chk) begin
      check("u0.stall", longint'(stall0), longint'(e0.stall));
      check("u0.fwd_sel1", longint'(sel1_0), longint'(e0.sel1));
      check("u0.fwd_sel2", longint'(sel2_0), longint'(e0.sel2));
      check("u0.inflight", longint'(infl0), longint'(popcnt(sh0)));
      check("u0.stall_cnt", longint'(cnt0_o), cnt0);
      check("u1.stall", longint'(stall1), longint'(e1.stall));
      check("u1.fwd_sel1", longint'(sel1_1), longint'(e1.sel1));
      check("u1.fwd_sel2", longint'(sel2_1), longint'(e1.sel2));
      check("u1.inflight", longint'(infl1), longint'(popcnt(sh1)));
      check("u1.stall_cnt", longint'(cnt1_o), cnt1);
    end
  endtask

  task automatic advance();
    ent_t n0, n1;
    @(posedge clk);
    n0.v    = id_valid && !flush && id_wb_en && !e0.stall;
    n0.dest = id_dest;
    n0.mr   = id_mem_r_en;
    n1      = n0;
    n1.v    = id_valid && !flush && id_wb_en && !e1.stall;
    if (!rst_n) begin
      foreach (sh0[k]) sh0[k] = killed(sh0[k]);
      foreach (sh1[k]) sh1[k] = killed(sh1[k]);
      cnt0 = 0;
      cnt1 = 0;
    end else begin
      if (id_valid && e0.haz && !flush && cnt0 < 64'hFFFF_FFFF) cnt0++;
      if (id_valid && e1.haz && !flush && cnt1 < 3) cnt1++;
      if (!pipe_hold) begin
        sh0.push_front(n0);
        void'(sh0.pop_back());
        sh1.push_front(n1);
        void'(sh1.pop_back());
      end
    end
    #1;
  endtask

  task automatic step();
    settle(1'b1);
    advance();
  endtask

  task automatic ins(input logic v, input int s1, input int s2, input logic imm, input logic sb,
                     input int d, input logic wb, input logic mr, input brcmd_t br);
    id_valid     = v;
    id_src1      = 5'(s1);
    id_src2      = 5'(s2);
    id_is_imm    = imm;
    id_st_or_bne = sb;
    id_dest      = 5'(d);
    id_wb_en     = wb;
    id_mem_r_en  = mr;
    id_br_cmd    = br;
  endtask

  task automatic bubbles(input int n);
    ins(0, 0, 0, 0, 0, 0, 0, 0, COND_JUMP);
    repeat (n) step();
  endtask

  initial begin
    ent_t z;
    z = '0;
    repeat (2) sh0.push_back(z);
    repeat (3) sh1.push_back(z);
    cnt0 = 0;
    cnt1 = 0;
    rst_n = 1'b0; forward_en = 1'b1; flush = 1'b0; pipe_hold = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0, COND_JUMP);
    settle(1'b0); advance();
    settle(1'b0); advance();
    rst_n = 1'b1;

    // reset state
    settle(1'b1);
    check("reset.inflight", longint'(infl0), 0);
    check("reset.stall_cnt", longint'(cnt0_o), 0);
    check("reset.stall", longint'(stall0), 0);
    advance();

    // ALU -> dependent ALU, forwarded from EXE then MEM
    ins(1, 1, 2, 0, 0, 3, 1, 0, COND_JUMP); step();
    ins(1, 3, 0, 1, 0, 8, 1, 0, COND_JUMP); settle(1'b1);
    check("alu_fwd.stall", longint'(stall0), 0);
    check("alu_fwd.sel1", longint'(sel1_0), 1);
    advance();
    ins(1, 9, 3, 0, 0, 10, 1, 0, COND_JUMP); settle(1'b1);
    check("alu_fwd.sel2", longint'(sel2_0), 2);
    advance();

    // load-use: one bubble, then forward from MEM
    bubbles(3);
    ins(1, 0, 0, 1, 0, 5, 1, 1, COND_JUMP); step();
    ins(1, 5, 0, 1, 0, 11, 1, 0, COND_JUMP); settle(1'b1);
    check("load_use.stall", longint'(stall0), 1);
    advance();
    settle(1'b1);
    check("load_use.stall_after", longint'(stall0), 0);
    check("load_use.sel1", longint'(sel1_0), 2);
    check("load_use.cnt", longint'(cnt0_o), 1);
    check("load_use.cnt_u1", longint'(cnt1_o), 1);
    advance();

    // BNE on a load result: stalls while k < 3 and the entry is still tracked
    bubbles(3);
    ins(1, 0, 0, 1, 0, 7, 1, 1, COND_JUMP); step();
    ins(1, 0, 7, 1, 1, 0, 0, 0, COND_BNE);
    ns0 = 0; ns1 = 0;
    repeat (4) begin
      settle(1'b1);
      if (stall0) ns0++;
      if (stall1) ns1++;
      advance();
    end
    check("bne.stalls_depth2", ns0, 2);
    check("bne.stalls_depth3", ns1, 3);
    ins(0, 0, 0, 0, 0, 0, 0, 0, COND_JUMP); settle(1'b1);
    check("bne.cnt", longint'(cnt0_o), 3);
    check("cnt_sat.cnt_w2", longint'(cnt1_o), 3);
    advance();

    // forwarding disabled: wait for the producer to leave the shadow
    forward_en = 1'b0;
    bubbles(3);
    ins(1, 0, 0, 1, 0, 4, 1, 0, COND_JUMP); step();
    ins(1, 4, 0, 1, 0, 12, 1, 0, COND_JUMP);
    ns0 = 0; ns1 = 0;
    repeat (4) begin
      settle(1'b1);
      if (stall0) ns0++;
      if (stall1) ns1++;
      check("nofwd.sel1", longint'(sel1_0), 0);
      advance();
    end
    check("nofwd.stalls_depth2", ns0, 2);
    check("nofwd.stalls_depth3", ns1, 3);

    // register 0 and immediate src2 never create a hazard
    bubbles(3);
    ins(1, 0, 0, 1, 0, 0, 1, 0, COND_JUMP); step();
    ins(1, 0, 0, 1, 0, 13, 1, 0, COND_JUMP); settle(1'b1);
    check("zero_reg.stall", longint'(stall0), 0);
    advance();
    bubbles(3);
    ins(1, 0, 0, 1, 0, 6, 1, 0, COND_JUMP); step();
    ins(1, 1, 6, 1, 0, 14, 1, 0, COND_JUMP); settle(1'b1);
    check("imm_src2.stall", longint'(stall0), 0);
    check("imm_src2.stall_u1", longint'(stall1), 0);
    advance();
    forward_en = 1'b1;

    // flush with a hazard: no stall, bubble inserted
    bubbles(3);
    ins(1, 0, 0, 1, 0, 5, 1, 1, COND_JUMP); step();
    ins(1, 5, 0, 1, 0, 15, 1, 0, COND_JUMP); flush = 1'b1;
    settle(1'b1);
    check("flush.stall", longint'(stall0), 0);
    advance();
    flush = 1'b0;
    ins(0, 0, 0, 0, 0, 0, 0, 0, COND_JUMP); settle(1'b1);
    check("flush.inflight", longint'(infl0), 1);
    check("flush.inflight_u1", longint'(infl1), 1);
    advance();

    // pipe_hold freezes the shadow
    bubbles(3);
    ins(1, 0, 0, 1, 0, 9, 1, 0, COND_JUMP); step();
    ins(1, 0, 0, 1, 0, 10, 1, 1, COND_JUMP); step();
    pipe_hold = 1'b1;
    ins(1, 20, 21, 0, 0, 22, 1, 0, COND_JUMP);
    repeat (3) begin
      settle(1'b1);
      check("hold.stall", longint'(stall0), 1);
      check("hold.inflight", longint'(infl0), 2);
      check("hold.inflight_u1", longint'(infl1), 2);
      advance();
    end
    pipe_hold = 1'b0;
    settle(1'b1);
    check("hold.release_inflight", longint'(infl0), 2);
    advance();

    // reset asserted during a stall
    bubbles(3);
    ins(1, 0, 0, 1, 0, 5, 1, 1, COND_JUMP); step();
    ins(1, 0, 5, 1, 1, 0, 0, 0, COND_BNE); settle(1'b1);
    check("rst_mid.stall_before", longint'(stall0), 1);
    advance();
    rst_n = 1'b0;
    settle(1'b1);
    check("rst_mid.stall_during", longint'(stall0), 1);
    advance();
    rst_n = 1'b1;
    settle(1'b1);
    check("rst_mid.stall_after", longint'(stall0), 0);
    check("rst_mid.stall_after_u1", longint'(stall1), 0);
    check("rst_mid.inflight", longint'(infl0), 0);
    check("rst_mid.cnt", longint'(cnt0_o), 0);
    advance();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ins($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          brcmd_t'($urandom_range(0, 2)));
      forward_en = $urandom_range(0, 7) != 0;
      flush      = $urandom_range(0, 15) == 0;
      pipe_hold  = $urandom_range(0, 9) == 0;
      rst_n      = $urandom_range(0, 63) != 0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
